// File: rtl/alu_ctrl_seq.sv
// ALU control decode with a multi-cycle multiply/divide stall sequencer.
// Build option: define ALU_CTRL_DIV_EN to decode and sequence divide.
module alu_ctrl_seq #(
    parameter int CTRL_W  = 4,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic [2:0]        aluop,
    input  logic [5:0]        funct,
    output logic [CTRL_W-1:0] gout,
    output logic              jmor,
    output logic              jalr,
    output logic              illegal,
    output logic              stall,
    output logic              hilo_we
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] op_q, op_d;

    logic [3:0] dec_code;
    logic       dec_jmor;
    logic       dec_jalr;
    logic       dec_ill;
    logic       dec_mul;
    logic       dec_div;
    logic [3:0] code;
    logic       launch;

    always_comb begin
        dec_code = 4'b0010;
        dec_jmor = 1'b0;
        dec_jalr = 1'b0;
        dec_ill  = 1'b0;
        dec_mul  = 1'b0;
        dec_div  = 1'b0;
        unique case (aluop)
            3'b000: dec_code = 4'b0010;
            3'b001: dec_code = 4'b0110;
            3'b011: dec_code = 4'b0000;
            3'b100: dec_code = 4'b0011;
            3'b010: begin
                case (funct)
                    6'b100000: dec_code = 4'b0010;
                    6'b100010: dec_code = 4'b0110;
                    6'b101010: dec_code = 4'b0111;
                    6'b100100: dec_code = 4'b0000;
                    6'b100101: begin
                        dec_code = 4'b0001;
                        dec_jmor = 1'b1;
                    end
                    6'b010111: dec_code = 4'b0001;
                    6'b001001: begin
                        dec_code = 4'b0010;
                        dec_jalr = 1'b1;
                    end
                    6'b000010: dec_code = 4'b0100;
                    6'b011000: begin
                        dec_code = 4'b1000;
                        dec_mul  = 1'b1;
                    end
`ifdef ALU_CTRL_DIV_EN
                    6'b011010: begin
                        dec_code = 4'b1001;
                        dec_div  = 1'b1;
                    end
`endif
                    default: dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end

    assign launch = valid && (dec_mul || dec_div);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        stall   = 1'b0;
        hilo_we = 1'b0;
        code    = dec_code;
        jmor    = dec_jmor;
        jalr    = dec_jalr;
        illegal = dec_ill;
        unique case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = BUSY;
                    cnt_d   = dec_div ? 8'(DIV_LAT - 1) : 8'(MUL_LAT - 1);
                    op_d    = dec_code;
                    stall   = 1'b1;
                end
            end
            BUSY: begin
                stall   = 1'b1;
                code    = op_q;
                jmor    = 1'b0;
                jalr    = 1'b0;
                illegal = 1'b0;
                if (cnt_q == 8'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DONE: begin
                // Stalled instruction retires here; valid is ignored
                hilo_we = 1'b1;
                code    = op_q;
                jmor    = 1'b0;
                jalr    = 1'b0;
                illegal = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign gout = CTRL_W'(code);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            op_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: per-cycle expected outputs are
// queued as stimulus is driven and compared when the cycle is sampled.
module tb_alu_ctrl_seq;

    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid;
    logic [2:0]    aluop;
    logic [5:0]    funct;
    logic [CW-1:0] gout;
    logic          jmor;
    logic          jalr;
    logic          illegal;
    logic          stall;
    logic          hilo_we;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string         tag;
        logic [CW-1:0] g;
        logic          jm;
        logic          jr;
        logic          il;
        logic          st;
        logic          hw;
    } exp_t;

    exp_t sb[$];

    alu_ctrl_seq #(
        .CTRL_W (CW),
        .MUL_LAT(4),
        .DIV_LAT(32)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .valid  (valid),
        .aluop  (aluop),
        .funct  (funct),
        .gout   (gout),
        .jmor   (jmor),
        .jalr   (jalr),
        .illegal(illegal),
        .stall  (stall),
        .hilo_we(hilo_we)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic v,
                        input logic [2:0] op, input logic [5:0] fn,
                        input logic [3:0] g, input logic jm, input logic jr,
                        input logic il, input logic st, input logic hw);
        exp_t e;
        reset = r;
        valid = v;
        aluop = op;
        funct = fn;
        e.tag = tag;
        e.g   = CW'(g);
        e.jm  = jm;
        e.jr  = jr;
        e.il  = il;
        e.st  = st;
        e.hw  = hw;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        chk({e.tag, ".gout"}, 32'(gout), 32'(e.g));
        chk({e.tag, ".jmor"}, 32'(jmor), 32'(e.jm));
        chk({e.tag, ".jalr"}, 32'(jalr), 32'(e.jr));
        chk({e.tag, ".ill"}, 32'(illegal), 32'(e.il));
        chk({e.tag, ".stall"}, 32'(stall), 32'(e.st));
        chk({e.tag, ".hilo"}, 32'(hilo_we), 32'(e.hw));
        @(posedge clk);
        #1;
    endtask

    localparam logic [5:0] F_MUL = 6'b011000;
    localparam logic [5:0] F_DIV = 6'b011010;

    // Mult launch, LAT busy cycles with disturbed inputs, done cycle
    task automatic run_mult(input string tag);
        step({tag, "_launch"}, 0, 1, 3'b010, F_MUL, 4'b1000, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++)
            step({tag, "_busy"}, 0, 1, 3'b010, 6'b100101,
                 4'b1000, 0, 0, 0, 1, 0);
        step({tag, "_done"}, 0, 1, 3'b001, 6'b111111,
             4'b1000, 0, 0, 0, 0, 1);
    endtask

    initial begin
        reset = 1'b1;
        valid = 1'b0;
        aluop = 3'b000;
        funct = 6'b000000;
        repeat (2) @(posedge clk);
        #1;

        step("reset", 1, 0, 3'b000, 6'd0, 4'b0010, 0, 0, 0, 0, 0);
        step("jmor", 0, 1, 3'b010, 6'b100101, 4'b0001, 1, 0, 0, 0, 0);

        step("op000", 0, 1, 3'b000, 6'b100101, 4'b0010, 0, 0, 0, 0, 0);
        step("op001", 0, 1, 3'b001, 6'b100101, 4'b0110, 0, 0, 0, 0, 0);
        step("op011", 0, 1, 3'b011, 6'b001001, 4'b0000, 0, 0, 0, 0, 0);
        step("op100", 0, 1, 3'b100, 6'd0, 4'b0011, 0, 0, 0, 0, 0);
        step("op110", 0, 1, 3'b110, 6'd0, 4'b0010, 0, 0, 1, 0, 0);
        step("op111", 0, 0, 3'b111, 6'b011000, 4'b0010, 0, 0, 1, 0, 0);

        step("f_add", 0, 1, 3'b010, 6'b100000, 4'b0010, 0, 0, 0, 0, 0);
        step("f_sub", 0, 1, 3'b010, 6'b100010, 4'b0110, 0, 0, 0, 0, 0);
        step("f_slt", 0, 1, 3'b010, 6'b101010, 4'b0111, 0, 0, 0, 0, 0);
        step("f_and", 0, 1, 3'b010, 6'b100100, 4'b0000, 0, 0, 0, 0, 0);
        step("f_or", 0, 1, 3'b010, 6'b010111, 4'b0001, 0, 0, 0, 0, 0);
        step("f_jalr", 0, 1, 3'b010, 6'b001001, 4'b0010, 0, 1, 0, 0, 0);
        step("f_srl", 0, 1, 3'b010, 6'b000010, 4'b0100, 0, 0, 0, 0, 0);
        step("f_bad", 0, 1, 3'b010, 6'b111111, 4'b0010, 0, 0, 1, 0, 0);

        step("mul_nv", 0, 0, 3'b010, F_MUL, 4'b1000, 0, 0, 0, 0, 0);
        step("mul_nv2", 0, 0, 3'b010, F_MUL, 4'b1000, 0, 0, 0, 0, 0);

        run_mult("mul1");
        step("post1", 0, 0, 3'b000, 6'd0, 4'b0010, 0, 0, 0, 0, 0);

        step("b2b_l", 0, 1, 3'b010, F_MUL, 4'b1000, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++)
            step("b2b_busy", 0, 1, 3'b010, F_MUL, 4'b1000, 0, 0, 0, 1, 0);
        step("b2b_done", 0, 1, 3'b010, F_MUL, 4'b1000, 0, 0, 0, 0, 1);
        run_mult("b2b2");
        step("post2", 0, 0, 3'b011, 6'd0, 4'b0000, 0, 0, 0, 0, 0);

        step("ab_l", 0, 1, 3'b010, F_MUL, 4'b1000, 0, 0, 0, 1, 0);
        step("ab_b1", 0, 0, 3'b000, 6'd0, 4'b1000, 0, 0, 0, 1, 0);
        step("ab_b2", 1, 0, 3'b000, 6'd0, 4'b1000, 0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++)
            step("ab_idle", 0, 0, 3'b000, 6'd0, 4'b0010, 0, 0, 0, 0, 0);
        run_mult("mul3");
        step("post3", 0, 0, 3'b001, 6'd0, 4'b0110, 0, 0, 0, 0, 0);

`ifdef ALU_CTRL_DIV_EN
        step("div_l", 0, 1, 3'b010, F_DIV, 4'b1001, 0, 0, 0, 1, 0);
        for (int i = 0; i < 32; i++)
            step("div_busy", 0, 1, 3'b000, 6'd0, 4'b1001, 0, 0, 0, 1, 0);
        step("div_done", 0, 1, 3'b000, 6'd0, 4'b1001, 0, 0, 0, 0, 1);
        step("div_post", 0, 0, 3'b000, 6'd0, 4'b0010, 0, 0, 0, 0, 0);
`else
        step("div_off", 0, 1, 3'b010, F_DIV, 4'b0010, 0, 0, 1, 0, 0);
        step("div_off2", 0, 1, 3'b010, F_DIV, 4'b0010, 0, 0, 1, 0, 0);
        step("div_post", 0, 0, 3'b000, 6'd0, 4'b0010, 0, 0, 0, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
